// File: rtl/alu_workload_gen_if.sv
// Handshake/bus bundle between alu_workload_gen and the ALU it feeds.
// master: the workload generator (drives ALU issue, reads start/mode).
// slave:  the consumer/controller side.
`timescale 1ns/1ps

interface alu_workload_gen_if;
  logic        start;
  logic [1:0]  mode;
  logic        alu_en;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        busy;
  logic [31:0] issued_cnt;

  modport master (
    input  start,
    input  mode,
    output alu_en,
    output alu_op,
    output alu_a,
    output alu_b,
    output busy,
    output issued_cnt
  );

  modport slave (
    output start,
    output mode,
    input  alu_en,
    input  alu_op,
    input  alu_a,
    input  alu_b,
    input  busy,
    input  issued_cnt
  );
endinterface

// File: rtl/alu_workload_gen.sv
// Framed ALU workload generator. Each FRAME_LEN-cycle frame issues K back-to-back
// operations (K chosen from mode at the frame boundary) followed by idle gap cycles.
// Optional feature macro: WLG_LFSR_EN selects LFSR-generated operands; without it
// operand A is the running issue count and operand B is the constant 200.
`timescale 1ns/1ps

module alu_workload_gen #(
  parameter int unsigned FRAME_LEN = 16,
  parameter logic [31:0] SEED      = 32'hACE1_2345
) (
  input logic                dfs_clk,
  input logic                rst,
  alu_workload_gen_if.master wl
);

  localparam int unsigned     FcntW    = $clog2(FRAME_LEN);
  // K must be able to hold FRAME_LEN itself, hence one extra bit.
  localparam int unsigned     KW       = FcntW + 1;
  localparam logic [FcntW-1:0] FcntLast = FcntW'(FRAME_LEN - 1);
  localparam logic [KW-1:0]   KLow     = KW'(FRAME_LEN / 8);
  localparam logic [KW-1:0]   KMed     = KW'(FRAME_LEN / 2);
  localparam logic [KW-1:0]   KHigh    = KW'(FRAME_LEN);
  localparam logic [31:0]     CntMax   = 32'hFFFF_FFFF;
`ifdef WLG_LFSR_EN
  localparam logic [31:0]     LfsrMask = 32'h8020_0003;  // x^32+x^22+x^2+x+1
  localparam logic [31:0]     RstB     = 32'd0;
`else
  localparam logic [31:0]     RstB     = 32'd200;
`endif

  if (FRAME_LEN < 8 || (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad_frame_len
    $error("alu_workload_gen: FRAME_LEN must be a power of two and at least 8");
  end
  if (SEED == 32'd0) begin : g_bad_seed
    $error("alu_workload_gen: SEED must be non-zero");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e           state_q, state_d;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic             alu_en_q, alu_en_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [2:0]       op_cnt_q, op_cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      issued_q, issued_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [KW-1:0]    k_new;
  logic [KW-1:0]    fcnt_inc;
  logic             issue;
`ifdef WLG_LFSR_EN
  logic [31:0]      lfsr_q, lfsr_d;
  logic [31:0]      lfsr_step;
`endif

  // Decode the issue count for a frame from the duty level.
  always_comb begin
    k_new = '0;
    case (wl.mode)
      2'b01:   k_new = KLow;
      2'b10:   k_new = KMed;
      2'b11:   k_new = KHigh;
      default: k_new = '0;
    endcase
  end

`ifdef WLG_LFSR_EN
  // One Galois step (right shift, feedback from bit 0).
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrMask : 32'd0);
  end
`endif

  // Next-state and registered-output logic for frame sequencing and operand generation.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    k_d      = k_q;
    busy_d   = busy_q;
    alu_op_d = alu_op_q;
    op_cnt_d = op_cnt_q;
    issued_d = issued_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    fcnt_inc = {1'b0, fcnt_q} + KW'(1);
`ifdef WLG_LFSR_EN
    lfsr_d   = lfsr_q;
`endif

    // Issue cycles are exactly the ISSUE state; the strobe appears one cycle later.
    issue    = (state_q == StIssue);
    alu_en_d = issue;

    if (issue) begin
      alu_op_d = op_cnt_q;
      op_cnt_d = op_cnt_q + 3'd1;
      issued_d = (issued_q == CntMax) ? issued_q : issued_q + 32'd1;
`ifdef WLG_LFSR_EN
      lfsr_d   = lfsr_step;
      alu_a_d  = lfsr_step;
      alu_b_d  = {lfsr_step[15:0], lfsr_step[31:16]};
`else
      alu_a_d  = issued_q;
`endif
    end

    case (state_q)
      StIdle: begin
        if (wl.start) begin
          k_d     = k_new;
          fcnt_d  = '0;
          busy_d  = 1'b1;
          state_d = (k_new != '0) ? StIssue : StGap;
        end
      end
      StIssue, StGap: begin
        if (fcnt_q == FcntLast) begin
          fcnt_d = '0;
          if (wl.start) begin
            // Back-to-back frames: re-latch K with no idle cycle in between.
            k_d     = k_new;
            state_d = (k_new != '0) ? StIssue : StGap;
          end else begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end else begin
          fcnt_d = fcnt_q + FcntW'(1);
          if (state_q == StIssue && fcnt_inc == k_q) begin
            state_d = StGap;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        fcnt_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  // All state and outputs registered; reset is asynchronous so outputs clear at once.
  always_ff @(posedge dfs_clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      fcnt_q   <= '0;
      k_q      <= '0;
      alu_en_q <= 1'b0;
      alu_op_q <= 3'd0;
      op_cnt_q <= 3'd0;
      busy_q   <= 1'b0;
      issued_q <= 32'd0;
      alu_a_q  <= 32'd0;
      alu_b_q  <= RstB;
`ifdef WLG_LFSR_EN
      lfsr_q   <= SEED;
`endif
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      k_q      <= k_d;
      alu_en_q <= alu_en_d;
      alu_op_q <= alu_op_d;
      op_cnt_q <= op_cnt_d;
      busy_q   <= busy_d;
      issued_q <= issued_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
`ifdef WLG_LFSR_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  assign wl.alu_en     = alu_en_q;
  assign wl.alu_op     = alu_op_q;
  assign wl.alu_a      = alu_a_q;
  assign wl.alu_b      = alu_b_q;
  assign wl.busy       = busy_q;
  assign wl.issued_cnt = issued_q;

endmodule

// File: tb/tb_alu_workload_gen.sv
// Self-checking bench for alu_workload_gen: directed frame scenarios plus random
// start/mode traffic, checked against a frame-level reference model.
`timescale 1ns/1ps

module tb_alu_workload_gen;

  localparam int FL = 16;
  localparam logic [31:0] SEED = 32'hACE1_2345;
`ifdef WLG_LFSR_EN
  localparam logic [31:0] RST_B = 32'd0;
`else
  localparam logic [31:0] RST_B = 32'd200;
`endif

  logic dfs_clk;
  logic rst;
  int   vecs;
  int   miss;

  alu_workload_gen_if wl_if ();

  alu_workload_gen #(
    .FRAME_LEN(FL),
    .SEED     (SEED)
  ) dut (
    .dfs_clk(dfs_clk),
    .rst    (rst),
    .wl     (wl_if.master)
  );

  initial begin
    dfs_clk = 1'b0;
    forever #5 dfs_clk = ~dfs_clk;
  end

  // ---------------- reference model ----------------
  function automatic int k_of(input logic [1:0] m);
    case (m)
      2'b01:   return FL / 8;
      2'b10:   return FL / 2;
      2'b11:   return FL;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  bit          m_run;      // a frame is in progress (== expected busy)
  int          m_pos;      // position within current frame
  int          m_k;        // issues in current frame
  int          m_issues;   // unsaturated issue count
  logic        e_en;
  logic [2:0]  e_op;
  logic [31:0] e_cnt;
  logic [31:0] e_a;
  logic [31:0] e_b;
  logic [31:0] m_lfsr;

  always @(posedge dfs_clk or posedge rst) begin
    if (rst) begin
      m_run    <= 1'b0;
      m_pos    <= 0;
      m_k      <= 0;
      m_issues <= 0;
      e_en     <= 1'b0;
      e_op     <= 3'd0;
      e_cnt    <= 32'd0;
      e_a      <= 32'd0;
      e_b      <= RST_B;
      m_lfsr   <= SEED;
    end else begin
      // The first K positions of a frame issue; outputs show them one cycle on.
      e_en <= m_run && (m_pos < m_k);
      if (m_run && (m_pos < m_k)) begin
        e_op     <= 3'(m_issues % 8);
        m_issues <= m_issues + 1;
        e_cnt    <= (e_cnt == 32'hFFFF_FFFF) ? e_cnt : e_cnt + 32'd1;
`ifdef WLG_LFSR_EN
        m_lfsr   <= lfsr_next(m_lfsr);
        e_a      <= lfsr_next(m_lfsr);
        e_b      <= {lfsr_next(m_lfsr) & 32'h0000_FFFF} << 16 | (lfsr_next(m_lfsr) >> 16);
`else
        e_a      <= e_cnt;
`endif
      end
      if (!m_run) begin
        if (wl_if.start) begin
          m_run <= 1'b1;
          m_pos <= 0;
          m_k   <= k_of(wl_if.mode);
        end
      end else if (m_pos == FL - 1) begin
        m_pos <= 0;
        if (wl_if.start) m_k <= k_of(wl_if.mode);
        else m_run <= 1'b0;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic apply_reset();
    wl_if.start = 1'b0;
    wl_if.mode  = 2'b00;
    rst = 1'b1;
    @(negedge dfs_clk);
    @(negedge dfs_clk);
    rst = 1'b0;
    @(negedge dfs_clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    vecs++;
    if ({wl_if.alu_en, wl_if.busy, wl_if.alu_op, wl_if.issued_cnt, wl_if.alu_a, wl_if.alu_b}
        !== {1'b0, 1'b0, 3'd0, 32'd0, 32'd0, RST_B}) begin
      miss++;
      $display("FAIL reset_values: got en=%b busy=%b op=%0d cnt=%0d a=%h b=%h, want 0 0 0 0 0 %h",
               wl_if.alu_en, wl_if.busy, wl_if.alu_op, wl_if.issued_cnt, wl_if.alu_a,
               wl_if.alu_b, RST_B);
    end
  endtask

  task automatic test_full_duty();
    int n_en;
    n_en = 0;
    apply_reset();
    wl_if.mode = 2'b11;
    for (int c = 0; c < 56; c++) begin
      wl_if.start = (c < 48);
      @(posedge dfs_clk);
      @(negedge dfs_clk);
      vecs++;
      if ({wl_if.alu_en, wl_if.busy, wl_if.alu_op, wl_if.issued_cnt, wl_if.alu_a, wl_if.alu_b}
          !== {e_en, m_run, e_op, e_cnt, e_a, e_b}) begin
        miss++;
        $display("FAIL full_model c=%0d: got en=%b busy=%b op=%0d cnt=%0d a=%h b=%h, want %b %b %0d %0d %h %h",
                 c, wl_if.alu_en, wl_if.busy, wl_if.alu_op, wl_if.issued_cnt, wl_if.alu_a,
                 wl_if.alu_b, e_en, m_run, e_op, e_cnt, e_a, e_b);
      end
      vecs++;
      if (wl_if.alu_en !== (c >= 1 && c <= 48)) begin
        miss++;
        $display("FAIL full_en c=%0d: got %b want %b", c, wl_if.alu_en, (c >= 1 && c <= 48));
      end
      if (wl_if.alu_en === 1'b1) begin
        vecs++;
        if (wl_if.alu_op !== 3'(n_en % 8)) begin
          miss++;
          $display("FAIL full_op c=%0d: got %0d want %0d", c, wl_if.alu_op, n_en % 8);
        end
        n_en++;
      end
    end
    vecs++;
    if (n_en != 48 || wl_if.issued_cnt !== 32'd48 || wl_if.busy !== 1'b0) begin
      miss++;
      $display("FAIL full_total: got issues=%0d cnt=%0d busy=%b want 48 48 0",
               n_en, wl_if.issued_cnt, wl_if.busy);
    end
  endtask

  task automatic test_half_duty();
    apply_reset();
    wl_if.mode = 2'b10;
    for (int c = 0; c < 24; c++) begin
      wl_if.start = (c < 16);
      @(posedge dfs_clk);
      @(negedge dfs_clk);
      vecs++;
      if ({wl_if.alu_en, wl_if.busy} !== {(c >= 1 && c <= 8), (c <= 15)}) begin
        miss++;
        $display("FAIL half_pattern c=%0d: got en=%b busy=%b want %b %b", c, wl_if.alu_en,
                 wl_if.busy, (c >= 1 && c <= 8), (c <= 15));
      end
    end
    vecs++;
    if (wl_if.issued_cnt !== 32'd8) begin
      miss++;
      $display("FAIL half_count: got %0d want 8", wl_if.issued_cnt);
    end
  endtask

  task automatic test_low_duty();
    logic want;
    apply_reset();
    wl_if.mode = 2'b01;
    for (int c = 0; c < 40; c++) begin
      wl_if.start = (c < 32);
      @(posedge dfs_clk);
      @(negedge dfs_clk);
      want = (c == 1 || c == 2 || c == 17 || c == 18);
      vecs++;
      if ({wl_if.alu_en, wl_if.busy} !== {want, (c <= 31)}) begin
        miss++;
        $display("FAIL low_pattern c=%0d: got en=%b busy=%b want %b %b", c, wl_if.alu_en,
                 wl_if.busy, want, (c <= 31));
      end
    end
    vecs++;
    if (wl_if.issued_cnt !== 32'd4) begin
      miss++;
      $display("FAIL low_count: got %0d want 4", wl_if.issued_cnt);
    end
  endtask

  task automatic test_mode_change();
    int f1;
    int f2;
    f1 = 0;
    f2 = 0;
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      wl_if.start = (c < 32);
      wl_if.mode  = (c < 5) ? 2'b01 : 2'b11;
      @(posedge dfs_clk);
      @(negedge dfs_clk);
      if (wl_if.alu_en === 1'b1) begin
        if (c <= 16) f1++;
        else f2++;
      end
    end
    vecs++;
    if (f1 != 2 || f2 != 16) begin
      miss++;
      $display("FAIL mode_change: got frame1=%0d frame2=%0d want 2 16", f1, f2);
    end
  endtask

  task automatic test_stop_mid();
    int n_en;
    n_en = 0;
    apply_reset();
    wl_if.mode = 2'b11;
    for (int c = 0; c < 30; c++) begin
      wl_if.start = (c < 3);
      @(posedge dfs_clk);
      @(negedge dfs_clk);
      if (wl_if.alu_en === 1'b1) n_en++;
      vecs++;
      if ({wl_if.alu_en, wl_if.busy} !== {(c >= 1 && c <= 16), (c <= 15)}) begin
        miss++;
        $display("FAIL stop_pattern c=%0d: got en=%b busy=%b want %b %b", c, wl_if.alu_en,
                 wl_if.busy, (c >= 1 && c <= 16), (c <= 15));
      end
    end
    vecs++;
    if (n_en != 16 || wl_if.issued_cnt !== 32'd16) begin
      miss++;
      $display("FAIL stop_total: got issues=%0d cnt=%0d want 16 16", n_en, wl_if.issued_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    apply_reset();
    wl_if.mode = 2'b11;
    for (int c = 0; c < 7; c++) begin
      wl_if.start = 1'b1;
      @(posedge dfs_clk);
      @(negedge dfs_clk);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if ({wl_if.alu_en, wl_if.busy, wl_if.alu_op, wl_if.issued_cnt}
        !== {1'b0, 1'b0, 3'd0, 32'd0}) begin
      miss++;
      $display("FAIL reset_async: got en=%b busy=%b op=%0d cnt=%0d want 0 0 0 0",
               wl_if.alu_en, wl_if.busy, wl_if.alu_op, wl_if.issued_cnt);
    end
    @(negedge dfs_clk);
    rst = 1'b0;
    wl_if.start = 1'b1;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(posedge dfs_clk);
      @(negedge dfs_clk);
      if (wl_if.alu_en === 1'b1) begin
        seen = 1'b1;
        vecs++;
`ifdef WLG_LFSR_EN
        if ({wl_if.alu_op, wl_if.alu_a} !== {3'd0, lfsr_next(SEED)}) begin
          miss++;
          $display("FAIL reset_first_issue: got op=%0d a=%h want 0 %h", wl_if.alu_op,
                   wl_if.alu_a, lfsr_next(SEED));
        end
`else
        if ({wl_if.alu_op, wl_if.alu_a, wl_if.alu_b} !== {3'd0, 32'd0, 32'd200}) begin
          miss++;
          $display("FAIL reset_first_issue: got op=%0d a=%0d b=%0d want 0 0 200",
                   wl_if.alu_op, wl_if.alu_a, wl_if.alu_b);
        end
`endif
      end
    end
    if (!seen) begin
      vecs++;
      miss++;
      $display("FAIL reset_restart_timeout: got no issue within 6 cycles, want one");
    end
    wl_if.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge dfs_clk);
      @(negedge dfs_clk);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        if ($urandom_range(0, 9) == 0) wl_if.start = ~wl_if.start;
        wl_if.mode = 2'($urandom_range(0, 3));
      end else begin
        wl_if.start = 1'b0;
      end
      @(posedge dfs_clk);
      @(negedge dfs_clk);
      vecs++;
      if ({wl_if.alu_en, wl_if.busy, wl_if.alu_op, wl_if.issued_cnt, wl_if.alu_a, wl_if.alu_b}
          !== {e_en, m_run, e_op, e_cnt, e_a, e_b}) begin
        miss++;
        $display("FAIL random_model c=%0d: got en=%b busy=%b op=%0d cnt=%0d a=%h b=%h, want %b %b %0d %0d %h %h",
                 c, wl_if.alu_en, wl_if.busy, wl_if.alu_op, wl_if.issued_cnt, wl_if.alu_a,
                 wl_if.alu_b, e_en, m_run, e_op, e_cnt, e_a, e_b);
      end
    end
  endtask

  initial begin
    vecs = 0;
    miss = 0;
    rst  = 1'b1;
    wl_if.start = 1'b0;
    wl_if.mode  = 2'b00;
    test_reset();
    test_full_duty();
    test_half_duty();
    test_low_duty();
    test_mode_change();
    test_stop_mid();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
